mem_map_ctrl: RTL and testbench

//  Parametrised 6502 memory-map controller, successor to the fixed decoder. Zero-page control

---
 rtl/nano6502_map_pkg.sv | 19 +
 rtl/ws_timer.sv | 46 ++++
 rtl/mem_map_ctrl.sv | 118 +++++++++++
 tb/tb_mem_map_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/nano6502_map_pkg.sv
// Shared constants for the nano6502 memory-map controller:
// zero-page register offsets, wait FSM states, default map.
package nano6502_map_pkg;

  localparam logic [2:0] REG_IO_L = 3'd0;
  localparam logic [2:0] REG_IO_H = 3'd1;
  localparam logic [2:0] REG_ROM  = 3'd2;
  localparam logic [2:0] REG_PAGE = 3'd3;
  localparam logic [2:0] REG_WAIT = 3'd4;

  localparam logic [7:0]  IO_PAGE_DEF  = 8'hFE;
  localparam logic [15:0] ROM_BASE_DEF = 16'hE000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ws_state_e;

endpackage

// File: rtl/ws_timer.sv
// IO wait-state timer: stalls the CPU for exactly cfg_i
// cycles per IO access, counting from the first stalled cycle.
module ws_timer
  import nano6502_map_pkg::*;
#(
  parameter int WS_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [WS_W-1:0] cfg_i,
  output logic            rdy_o
);

  localparam logic [WS_W-1:0] ONE = 1;

  ws_state_e       state_q;
  logic [WS_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && cfg_i != '0) begin
            cnt_q   <= cfg_i - ONE;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - ONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The first stall cycle is decided combinationally in IDLE
  assign rdy_o = (state_q == ST_IDLE)
               ? !(start_i && cfg_i != '0)
               : (cnt_q == '0);

endmodule

// File: rtl/mem_map_ctrl.sv
// 6502 memory-map controller: zero-page control registers,
// ROM/IO/RAM decode, paged RAM window and IO wait states.
module mem_map_ctrl
  import nano6502_map_pkg::*;
#(
  parameter int          N_IO     = 4,
  parameter logic [7:0]  IO_PAGE  = IO_PAGE_DEF,
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEF,
  parameter int          PAGE_W   = 4,
  parameter int          WS_W     = 3,
  localparam int         RA_W     = PAGE_W + 14
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            R_W_n,
  input  logic [15:0]     addr_i,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  output logic            reg_cs,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [RA_W-1:0] ram_addr_o,
  output logic            rom_cs,
  output logic [N_IO-1:0] io_cs,
  output logic            io_we,
  output logic            rdy_o
);

  logic [7:0]        io_bank_l_q;
  logic [7:0]        io_bank_h_q;
  logic              rom_sel_q;
  logic [PAGE_W-1:0] ram_page_q;
  logic [WS_W-1:0]   wait_cfg_q;

  logic zp_hit, io_pg, rom_rng, reg_we;

  assign zp_hit  = (addr_i[15:3] == '0) && (addr_i[2:0] <= REG_WAIT);
  assign io_pg   = (addr_i[15:8] == IO_PAGE);
  assign rom_rng = (addr_i >= ROM_BASE) && (addr_i != 16'hFFFF);
  assign reg_we  = reg_cs && !R_W_n && rdy_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      io_bank_l_q <= '0;
      io_bank_h_q <= '0;
      rom_sel_q   <= 1'b0;
      ram_page_q  <= '0;
      wait_cfg_q  <= '0;
    end else if (reg_we) begin
      case (addr_i[2:0])
        REG_IO_L: io_bank_l_q <= data_i;
        REG_IO_H: io_bank_h_q <= data_i;
        REG_ROM:  rom_sel_q   <= data_i[0];
        REG_PAGE: ram_page_q  <= data_i[PAGE_W-1:0];
        REG_WAIT: wait_cfg_q  <= data_i[WS_W-1:0];
        default: ;
      endcase
    end
  end

  // Ranges overlap (IO page lies inside ROM), so order decides
  always_comb begin
    reg_cs = 1'b0;
    ram_cs = 1'b0;
    rom_cs = 1'b0;
    io_cs  = '0;
    priority case (1'b1)
      zp_hit: reg_cs = 1'b1;
      io_pg: begin
        if (io_bank_l_q == '0) begin
          rom_cs = 1'b1;
        end else if (io_bank_l_q <= 8'(N_IO)) begin
          for (int k = 0; k < N_IO; k++)
            io_cs[k] = (io_bank_l_q == 8'(k + 1));
        end else begin
          ram_cs = 1'b1;
        end
      end
      (rom_rng && !rom_sel_q): rom_cs = 1'b1;
      default: ram_cs = 1'b1;
    endcase
  end

  always_comb begin
    data_o = '0;
    if (reg_cs) begin
      case (addr_i[2:0])
        REG_IO_L: data_o = io_bank_l_q;
        REG_IO_H: data_o = io_bank_h_q;
        REG_ROM:  data_o = {7'b0, rom_sel_q};
        REG_PAGE: data_o = 8'(ram_page_q);
        REG_WAIT: data_o = 8'(wait_cfg_q);
        default:  data_o = '0;
      endcase
    end
  end

  always_comb begin
    if (addr_i[15:14] == 2'b10)
      ram_addr_o = {ram_page_q, addr_i[13:0]};
    else
      ram_addr_o = RA_W'(addr_i);
  end

  assign ram_we = ram_cs && !R_W_n;
  assign io_we  = (|io_cs) && !R_W_n && rdy_o;

  ws_timer #(
    .WS_W (WS_W)
  ) u_ws_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (|io_cs),
    .cfg_i   (wait_cfg_q),
    .rdy_o   (rdy_o)
  );

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Bench for mem_map_ctrl: directed map scenarios, then random
// bus traffic checked against a transaction-level memory-map model.
module tb_mem_map_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        R_W_n;
  logic [15:0] addr_i;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        reg_cs, ram_cs, ram_we, rom_cs, io_we, rdy_o;
  logic [17:0] ram_addr_o;
  logic [3:0]  io_cs;

  int errs   = 0;
  int checks = 0;

  logic [7:0] m_reg  [5];
  logic [7:0] m_mask [5];

  mem_map_ctrl dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .R_W_n      (R_W_n),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .reg_cs     (reg_cs),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr_o (ram_addr_o),
    .rom_cs     (rom_cs),
    .io_cs      (io_cs),
    .io_we      (io_we),
    .rdy_o      (rdy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
  endtask

  // One CPU bus cycle, including any wait states; entered at posedge+1
  task automatic access(input logic [15:0] a,
                        input logic w,
                        input logic [7:0] d);
    logic e_reg, e_rom, e_ram;
    logic [3:0]  e_io;
    logic [7:0]  e_do;
    int          e_ra;
    int          stall;
    e_reg = 0; e_rom = 0; e_ram = 0; e_io = '0; e_do = '0;
    if (a <= 16'd4) begin
      e_reg = 1;
      e_do  = m_reg[a];
    end else if (a[15:8] == 8'hFE) begin
      if (m_reg[0] == 0)      e_rom = 1;
      else if (m_reg[0] <= 4) e_io = 4'(1 << (m_reg[0] - 1));
      else                    e_ram = 1;
    end else if (a >= 16'hE000 && a < 16'hFFFF && m_reg[2] == 0) begin
      e_rom = 1;
    end else begin
      e_ram = 1;
    end
    if (a >= 16'h8000 && a < 16'hC000)
      e_ra = int'(m_reg[3]) * 16384 + int'(a) % 16384;
    else
      e_ra = int'(a);
    stall = (e_io != 0) ? int'(m_reg[4]) : 0;

    addr_i = a; R_W_n = !w; data_i = d;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      check("rdy_stall", 32'(rdy_o), 0);
      check("io_we_stall", 32'(io_we), 0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("rdy", 32'(rdy_o), 1);
    check("reg_cs", 32'(reg_cs), 32'(e_reg));
    check("rom_cs", 32'(rom_cs), 32'(e_rom));
    check("ram_cs", 32'(ram_cs), 32'(e_ram));
    check("io_cs", 32'(io_cs), 32'(e_io));
    check("ram_addr", 32'(ram_addr_o), 32'(e_ra[17:0]));
    check("data_o", 32'(data_o), 32'(e_do));
    check("ram_we", 32'(ram_we), 32'(e_ram & w));
    check("io_we", 32'(io_we), 32'((e_io != 0) & w));
    @(posedge clk_i); #1;
    if (w && e_reg) m_reg[a] = d & m_mask[a];
  endtask

  initial begin
    m_mask[0] = 8'hFF; m_mask[1] = 8'hFF; m_mask[2] = 8'h01;
    m_mask[3] = 8'h0F; m_mask[4] = 8'h07;
    model_reset();
    rst_n_i = 0; R_W_n = 1; addr_i = 16'hFE10; data_i = 0;
    repeat (2) @(posedge clk_i);
    #1 check("rst_rdy", 32'(rdy_o), 1);
    rst_n_i = 1;

    access(16'hFE10, 0, 0);
    access(16'h0002, 0, 0);

    access(16'h0000, 1, 8'h02);
    access(16'hFE00, 0, 0);
    access(16'h0000, 1, 8'h07);
    access(16'hFE00, 0, 0);

    access(16'h0000, 1, 8'h01);
    access(16'h0004, 1, 8'h03);
    access(16'hFE40, 0, 0);
    access(16'hFE40, 1, 8'hA5);
    access(16'hFE40, 1, 8'h5A);

    access(16'h0003, 1, 8'h05);
    access(16'h9234, 0, 0);
    access(16'hC000, 0, 0);

    access(16'h0002, 1, 8'h01);
    access(16'hE000, 0, 0);
    access(16'hFFFF, 0, 0);
    access(16'h0000, 1, 8'h00);
    access(16'hFE00, 0, 0);
    access(16'h0004, 1, 8'h07);
    access(16'h0000, 1, 8'h04);
    access(16'hFEFF, 1, 8'h11);

    // Reset asserted during the second stall cycle of a 5-cycle wait
    access(16'h0004, 1, 8'h05);
    access(16'h0000, 1, 8'h02);
    addr_i = 16'hFE00; R_W_n = 1;
    @(negedge clk_i);
    check("mid_stall1", 32'(rdy_o), 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("mid_stall2", 32'(rdy_o), 0);
    rst_n_i = 0; #1;
    model_reset();
    check("rst_mid_rdy", 32'(rdy_o), 1);
    check("rst_mid_rom", 32'(rom_cs), 1);
    @(posedge clk_i); #1;
    rst_n_i = 1;
    access(16'h0000, 1, 8'h02);
    access(16'hFE00, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        w;
      w = $urandom_range(0, 1) == 1;
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin
          a = 16'($urandom_range(0, 6));
          if (a == 0) d = 8'($urandom_range(0, 6));
        end
        1, 2: a = {8'hFE, 8'($urandom)};
        3: a = 16'($urandom_range(16'hE000, 16'hFFFF));
        4: a = 16'($urandom_range(16'h8000, 16'hBFFF));
        default: a = 16'($urandom);
      endcase
      access(a, w, d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
